fios_pe_sequencer: RTL and testbench
====================================

Name: fios_pe_sequencer

Overview:
- Moore-style control sequencer for one FIOS Montgomery PE with a single DSP48E2 and 17-bit words.
- Per outer iteration i it generates every PE control signal: operand register enables, A/B/C mux selects, CREG enable, OPMODE, RES delay enable.
- It also drives the word index used to fetch a_i, b_j, p_j and t_j.
- Sits between the top-level start/done handshake and the PE chain head; the control outputs are delayed down the chain outside this block.

Parameters:
- S, 8, number of 17-bit words per operand; legal range S >= 2.
- LAT, 4, cycles from DSP operand issue to RES valid; legal range LAT >= 1.

Ports:
- clock_i  in  1  single clock.
- reset_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- busy_o  out  1  high from the first LOAD cycle through DONE inclusive.
- done_o  out  1  one-cycle completion pulse.
- iter_o  out  clog2(S)  outer index i.
- idx_o  out  clog2(S)  word index for b/p/t fetch (a fetch in LOAD).
- a_reg_en_o  out  1  PE a register enable.
- m_reg_en_o  out  1  PE m register enable.
- mux_A_sel_o  out  2  0 = a, 1 = RES, 2 = m.
- mux_B_sel_o  out  2  0 = b, 1 = p'0, 2 = p.
- mux_C_sel_o  out  2  0 = C_i, 1 = RES_delay, 2 = C 1-delay.
- CREG_en_o  out  1  DSP C register enable.
- OPMODE_o  out  9  DSP48E2 OPMODE.
- RES_delay_en_o  out  1  PE feedback capture enable.

Behaviour:
- Reset and IDLE outputs:
  - All outputs are driven from registers; all update on the same edge as the state change.
  - On reset (reset_n_i low at an edge), the next cycle is IDLE.
  - In IDLE and on reset, every output is 0 and OPMODE_o = 9'h000.
- Reset mid-operation: abort immediately. No done_o; counters cleared.
- IDLE -> LOAD when start_i = 1, with i = 0. start_i in any other state is ignored.
- Per-iteration schedule; each state drives the listed outputs, all others are 0:
  - LOAD, 1 cycle: a_reg_en_o = 1, idx_o = i.
  - T0, 1 cycle: A = 0, B = 0, C = 0, CREG_en_o = 1, OPMODE = 9'h035 (A*B + C), idx_o = 0.
  - WT0, LAT-1 cycles: OPMODE = 9'h000. Skipped if LAT = 1.
  - M, 1 cycle: A = 1, B = 1, OPMODE = 9'h005 (A*B), RES_delay_en_o = 1.
  - WM, LAT-1 cycles: idle. Skipped if LAT = 1.
  - CAPM, 1 cycle: m_reg_en_o = 1.
  - J, 2S cycles, sub-counter k = 0..2S-1, j = k/2, idx_o = j:
    - even k, j = 0: A = 0, B = 0, C = 1, CREG_en_o = 1, OPMODE = 9'h035.
    - even k, j > 0: A = 0, B = 0, C = 2, CREG_en_o = 1, OPMODE = 9'h1E5 (A*B + C + P>>17).
    - odd k: A = 2, B = 2, OPMODE = 9'h025 (A*B + P).
  - DRAIN, LAT cycles: idle, RES_delay_en_o = 1 on the final cycle.
  - After DRAIN: if i = S-1 go to DONE, else i <= i+1 and go to LOAD.
- DONE, 1 cycle: done_o = 1, busy_o = 1, then IDLE.
- Timing:
  - Iteration length P = 3*LAT + 2*S + 2 cycles.
  - If start_i is sampled at edge k, LOAD occupies cycle k+1 and done_o is high in cycle k+1+S*P.
  - With defaults P = 30 and done_o lands at cycle k+241.
  - Back-to-back operation: start_i high during DONE is ignored; a new start is accepted the cycle after DONE, in IDLE.
- Counters: wait counter is clog2(LAT+1) bits, k is clog2(2S) bits, i is clog2(S) bits. No wrap except the explicit reset to 0 on leaving each state.

Test Plan:
- Reset: hold reset_n_i = 0 for 3 cycles with start_i = 1 -> all outputs 0, OPMODE 9'h000, busy_o = 0, no state advance.
- Single run, S = 8, LAT = 4: start pulse at cycle 10 ->
  - busy_o rises at cycle 11; done_o is high only at cycle 251.
  - Exactly 8 a_reg_en_o pulses and 8 m_reg_en_o pulses.
  - m_reg_en_o occurs 2*LAT+1 = 9 cycles after each a_reg_en_o.
- J-phase decode: in iteration 0, check the cycle-by-cycle pattern:
  - idx_o sequence is 0,0,1,1,...,7,7.
  - OPMODE sequence is 035,025,1E5,025,...
  - mux_C_sel_o is 1 at k = 0 and 2 at even k > 0.
  - CREG_en_o is high on even k only.
- LAT = 1, S = 2: P = 9 -> WT0 and WM are absent; M immediately follows T0; done_o at start+19.
- Reset mid-run: assert reset_n_i = 0 during iteration 3, J phase ->
  - next cycle is IDLE with all outputs 0 and no done_o.
  - A subsequent start gives the full-length run with iter_o restarting at 0.
- start_i held high continuously ->
  - runs repeat with exactly one IDLE cycle between DONE and the next LOAD.
  - start_i is ignored while busy_o = 1.

Source files
------------

// File: rtl/fios_pe_sequencer_if.sv
// Control bundle between the FIOS PE sequencer and the head of the PE chain.
// The start/done handshake and every per-cycle PE control travel together.
interface fios_pe_sequencer_if #(
    parameter int S = 8
);
    localparam int IW = $clog2(S);

    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic [IW-1:0] iter_o;
    logic [IW-1:0] idx_o;
    logic          a_reg_en_o;
    logic          m_reg_en_o;
    logic [1:0]    mux_A_sel_o;
    logic [1:0]    mux_B_sel_o;
    logic [1:0]    mux_C_sel_o;
    logic          CREG_en_o;
    logic [8:0]    OPMODE_o;
    logic          RES_delay_en_o;

    modport master (
        input  start_i,
        output busy_o, done_o, iter_o, idx_o, a_reg_en_o, m_reg_en_o,
               mux_A_sel_o, mux_B_sel_o, mux_C_sel_o, CREG_en_o, OPMODE_o,
               RES_delay_en_o
    );

    modport slave (
        output start_i,
        input  busy_o, done_o, iter_o, idx_o, a_reg_en_o, m_reg_en_o,
               mux_A_sel_o, mux_B_sel_o, mux_C_sel_o, CREG_en_o, OPMODE_o,
               RES_delay_en_o
    );
endinterface

// File: rtl/fios_pe_sequencer.sv
// Moore control sequencer for one FIOS Montgomery PE built on a single DSP48E2.
// Walks S outer iterations of LOAD/T0/WT0/M/WM/CAPM/J/DRAIN and pulses done.
module fios_pe_sequencer #(
    parameter int S   = 8,
    parameter int LAT = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    fios_pe_sequencer_if.master  bus
);
    localparam int IW = $clog2(S);
    localparam int KW = $clog2(2 * S);
    localparam int WW = $clog2(LAT + 1);

    localparam logic [WW-1:0] WT_LAST = WW'((LAT > 1) ? LAT - 2 : 0);
    localparam logic [WW-1:0] DR_LAST = WW'(LAT - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(2 * S - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(S - 1);

    localparam logic [8:0] OP_ABC    = 9'h035;
    localparam logic [8:0] OP_AB     = 9'h005;
    localparam logic [8:0] OP_ABP    = 9'h025;
    localparam logic [8:0] OP_ABCSHF = 9'h1E5;

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_T0, ST_WT0, ST_M, ST_WM, ST_CAPM, ST_J, ST_DRAIN, ST_DONE
    } state_e;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [IW-1:0] iter;
        logic [IW-1:0] idx;
        logic          a_reg_en;
        logic          m_reg_en;
        logic [1:0]    mux_a;
        logic [1:0]    mux_b;
        logic [1:0]    mux_c;
        logic          creg_en;
        logic [8:0]    opmode;
        logic          res_delay_en;
    } ctl_t;

    state_e        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [KW-1:0] k_q, k_d;
    logic [WW-1:0] wait_q, wait_d;
    ctl_t          ctl_q, ctl_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        iter_d  = iter_q;
        k_d     = k_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                iter_d = '0;
                if (bus.start_i) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_T0;
            ST_T0:   state_d = (LAT > 1) ? ST_WT0 : ST_M;
            ST_WT0: begin
                if (wait_q == WT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_M;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_M:    state_d = (LAT > 1) ? ST_WM : ST_CAPM;
            ST_WM: begin
                if (wait_q == WT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_CAPM;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_CAPM: begin
                k_d     = '0;
                state_d = ST_J;
            end
            ST_J: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                if (wait_q == DR_LAST) begin
                    wait_d = '0;
                    if (iter_q == I_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        iter_d  = iter_q + IW'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_DONE: begin
                iter_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: outputs are decoded from the next-state values and registered, so they change on the same edge as the state.
    always_comb begin
        ctl_d      = '0;
        ctl_d.busy = (state_d != ST_IDLE);
        ctl_d.done = (state_d == ST_DONE);
        ctl_d.iter = iter_d;
        unique case (state_d)
            ST_LOAD: begin
                ctl_d.a_reg_en = 1'b1;
                ctl_d.idx      = iter_d;
            end
            ST_T0: begin
                ctl_d.creg_en = 1'b1;
                ctl_d.opmode  = OP_ABC;
            end
            ST_M: begin
                ctl_d.mux_a        = 2'd1;
                ctl_d.mux_b        = 2'd1;
                ctl_d.opmode       = OP_AB;
                ctl_d.res_delay_en = 1'b1;
            end
            ST_CAPM: ctl_d.m_reg_en = 1'b1;
            ST_J: begin
                ctl_d.idx = k_d[KW-1:1];
                if (k_d[0]) begin
                    ctl_d.mux_a  = 2'd2;
                    ctl_d.mux_b  = 2'd2;
                    ctl_d.opmode = OP_ABP;
                end else begin
                    ctl_d.creg_en = 1'b1;
                    ctl_d.mux_c   = (k_d == '0) ? 2'd1 : 2'd2;
                    ctl_d.opmode  = (k_d == '0) ? OP_ABC : OP_ABCSHF;
                end
            end
            ST_DRAIN: ctl_d.res_delay_en = (wait_d == DR_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.busy_o         = ctl_q.busy;
    assign bus.done_o         = ctl_q.done;
    assign bus.iter_o         = ctl_q.iter;
    assign bus.idx_o          = ctl_q.idx;
    assign bus.a_reg_en_o     = ctl_q.a_reg_en;
    assign bus.m_reg_en_o     = ctl_q.m_reg_en;
    assign bus.mux_A_sel_o    = ctl_q.mux_a;
    assign bus.mux_B_sel_o    = ctl_q.mux_b;
    assign bus.mux_C_sel_o    = ctl_q.mux_c;
    assign bus.CREG_en_o      = ctl_q.creg_en;
    assign bus.OPMODE_o       = ctl_q.opmode;
    assign bus.RES_delay_en_o = ctl_q.res_delay_en;
endmodule

// File: tb/tb_fios_pe_sequencer.sv
// Bench for fios_pe_sequencer: two instances (S=8/LAT=4 and S=2/LAT=1) compared
// every cycle against a positional schedule model, with randomized start traffic.
module tb_fios_pe_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    fios_pe_sequencer_if #(.S(8)) bus0 ();
    fios_pe_sequencer_if #(.S(2)) bus1 ();

    fios_pe_sequencer #(.S(8), .LAT(4)) dut0 (.clock_i(clk), .reset_n_i(rst_n), .bus(bus0));
    fios_pe_sequencer #(.S(2), .LAT(1)) dut1 (.clock_i(clk), .reset_n_i(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: whether a run is active and the edge that accepted its start.
    bit v0, v1;
    int k0, k1;
    bit stats_on, b2b_on;
    int a_cnt, m_cnt, done_cnt, done_cyc, last_a, last_done0;

    // Expected output vector t cycles after the LOAD of the first iteration.
    // Layout: busy,done,iter[4],idx[4],a_en,m_en,muxA[2],muxB[2],muxC[2],creg,opmode[9],res.
    function automatic logic [28:0] model(int s, int lat, int t);
        logic busy, done, a, m, cr, res;
        logic [3:0] it, ix;
        logic [1:0] ma, mb, mc;
        logic [8:0] op;
        int p, r, k;
        {busy, done, a, m, cr, res} = '0;
        it = '0; ix = '0; ma = '0; mb = '0; mc = '0; op = '0;
        p = 3 * lat + 2 * s + 2;
        if (t >= 0 && t < s * p) begin
            busy = 1'b1;
            it   = 4'(t / p);
            r    = t % p;
            if (r == 0) begin
                a = 1'b1; ix = 4'(t / p);
            end else if (r == 1) begin
                cr = 1'b1; op = 9'h035;
            end else if (r <= lat) begin
                op = 9'h000;
            end else if (r == lat + 1) begin
                ma = 2'd1; mb = 2'd1; op = 9'h005; res = 1'b1;
            end else if (r <= 2 * lat) begin
                op = 9'h000;
            end else if (r == 2 * lat + 1) begin
                m = 1'b1;
            end else if (r < 2 * lat + 2 + 2 * s) begin
                k  = r - (2 * lat + 2);
                ix = 4'(k / 2);
                if (k % 2 == 1) begin
                    ma = 2'd2; mb = 2'd2; op = 9'h025;
                end else begin
                    cr = 1'b1;
                    mc = (k == 0) ? 2'd1 : 2'd2;
                    op = (k == 0) ? 9'h035 : 9'h1E5;
                end
            end else begin
                res = (r == p - 1);
            end
        end else if (t == s * p) begin
            busy = 1'b1; done = 1'b1; it = 4'(s - 1);
        end
        return {busy, done, it, ix, a, m, ma, mb, mc, cr, op, res};
    endfunction

    function automatic logic [28:0] exp0();
        return v0 ? model(8, 4, cyc - k0 - 1) : '0;
    endfunction

    function automatic logic [28:0] exp1();
        return v1 ? model(2, 1, cyc - k1 - 1) : '0;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: model the start handshake, advance, then compare both DUTs.
    task automatic step();
        logic [28:0] e;
        logic [28:0] o0, o1;
        bit acc0, acc1;
        e    = exp0();
        acc0 = rst_n && bus0.start_i && !e[28];
        e    = exp1();
        acc1 = rst_n && bus1.start_i && !e[28];
        if (!rst_n) begin
            v0 = 1'b0; v1 = 1'b0;
        end else begin
            if (acc0) begin v0 = 1'b1; k0 = cyc; end
            if (acc1) begin v1 = 1'b1; k1 = cyc; end
        end
        @(posedge clk);
        cyc++;
        #1;
        o0 = {bus0.busy_o, bus0.done_o, 4'(bus0.iter_o), 4'(bus0.idx_o), bus0.a_reg_en_o,
              bus0.m_reg_en_o, bus0.mux_A_sel_o, bus0.mux_B_sel_o, bus0.mux_C_sel_o,
              bus0.CREG_en_o, bus0.OPMODE_o, bus0.RES_delay_en_o};
        o1 = {bus1.busy_o, bus1.done_o, 4'(bus1.iter_o), 4'(bus1.idx_o), bus1.a_reg_en_o,
              bus1.m_reg_en_o, bus1.mux_A_sel_o, bus1.mux_B_sel_o, bus1.mux_C_sel_o,
              bus1.CREG_en_o, bus1.OPMODE_o, bus1.RES_delay_en_o};
        check("dut0_ctl", o0, exp0());
        check("dut1_ctl", o1, exp1());
        if (stats_on) begin
            if (bus0.a_reg_en_o) begin a_cnt++; last_a = cyc; end
            if (bus0.m_reg_en_o) begin
                m_cnt++;
                check("m_after_a", cyc - last_a, 9);
            end
            if (bus0.done_o) begin done_cnt++; done_cyc = cyc; end
        end
        if (b2b_on) begin
            if (bus0.a_reg_en_o && bus0.iter_o == '0 && last_done0 >= 0)
                check("b2b_gap", cyc - last_done0, 2);
            if (bus0.done_o) last_done0 = cyc;
        end
        if (bus1.done_o && v1) check("dut1_done_at", cyc - k1, 19);
    endtask

    task automatic clear_stats();
        a_cnt = 0; m_cnt = 0; done_cnt = 0; done_cyc = -1; last_a = -100;
    endtask

    task automatic single_run(string tag);
        int kstart;
        clear_stats();
        stats_on = 1'b1;
        bus0.start_i = 1'b1;
        step();
        kstart = k0;
        for (int n = 0; n < 245; n++) begin
            logic [28:0] e;
            e = exp0();
            bus0.start_i = e[28] ? 1'($urandom_range(0, 1)) : 1'b0;
            bus1.start_i = ($urandom_range(0, 3) == 0);
            step();
        end
        bus0.start_i = 1'b0;
        stats_on = 1'b0;
        check({tag, "_a_pulses"}, a_cnt, 8);
        check({tag, "_m_pulses"}, m_cnt, 8);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, kstart + 241);
    endtask

    initial begin
        int target;
        checks = 0; errors = 0; cyc = 0;
        v0 = 1'b0; v1 = 1'b0; k0 = 0; k1 = 0;
        stats_on = 1'b0; b2b_on = 1'b0; last_done0 = -1;
        clear_stats();

        // Reset held with start asserted: everything stays idle.
        rst_n = 1'b0;
        bus0.start_i = 1'b1;
        bus1.start_i = 1'b1;
        for (int n = 0; n < 3; n++) step();
        check("reset_busy0", bus0.busy_o, 1'b0);
        check("reset_opmode0", bus0.OPMODE_o, 9'h000);
        rst_n = 1'b1;
        bus0.start_i = 1'b0;
        bus1.start_i = 1'b0;

        for (int n = 0; n < 4 + int'($urandom_range(0, 5)); n++) step();

        single_run("run1");

        // Reset during iteration 3, J phase, then a clean full-length run.
        bus0.start_i = 1'b1;
        step();
        bus0.start_i = 1'b0;
        target = 3 * 30 + 10 + int'($urandom_range(0, 15));
        for (int n = 0; n < 200 && (cyc - k0 - 1) < target; n++) step();
        check("midrun_in_j_iter3", bus0.iter_o, 4'd3);
        rst_n = 1'b0;
        step();
        check("midrun_abort_busy", bus0.busy_o, 1'b0);
        check("midrun_abort_done", bus0.done_o, 1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) step();
        single_run("run2");

        // start_i held high: repeated runs, one IDLE cycle between DONE and LOAD.
        clear_stats();
        stats_on = 1'b1;
        b2b_on = 1'b1;
        last_done0 = -1;
        bus0.start_i = 1'b1;
        for (int n = 0; n < 2 * 242 + 4; n++) begin
            bus1.start_i = ($urandom_range(0, 1) == 0);
            step();
        end
        bus0.start_i = 1'b0;
        bus1.start_i = 1'b0;
        stats_on = 1'b0;
        b2b_on = 1'b0;
        check("b2b_done_count", done_cnt, 2);
        check("b2b_a_pulses", a_cnt, 17);
        for (int n = 0; n < 250; n++) step();
        check("final_idle0", bus0.busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
